// File: rtl/lsu_queue_if.sv
// ============================================================================
// Module      : lsu_queue_if
// Description : Execute-side request, memory-side issue and writeback bundle
//               for the load/store queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_queue_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int TAG_W  = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_base;
    logic [15:0]       req_offset;
    logic [WORD_W-1:0] req_wdata;
    logic [TAG_W-1:0]  req_tag;

    logic              mem_order;
    logic              mem_io;
    logic [ADDR_W-1:0] mem_address;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_accepted;
    logic [WORD_W-1:0] mem_rdata;

    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [WORD_W-1:0] wb_data;

    logic              misalign;
    logic [ADDR_W-1:0] misalign_addr;
    logic              busy;

    modport slave (
        input  req_valid, req_we, req_base, req_offset, req_wdata, req_tag,
        input  mem_accepted, mem_rdata,
        output req_ready, mem_order, mem_io, mem_address, mem_wdata,
        output wb_valid, wb_tag, wb_data, misalign, misalign_addr, busy
    );

    modport master (
        output req_valid, req_we, req_base, req_offset, req_wdata, req_tag,
        output mem_accepted, mem_rdata,
        input  req_ready, mem_order, mem_io, mem_address, mem_wdata,
        input  wb_valid, wb_tag, wb_data, misalign, misalign_addr, busy
    );
endinterface

`default_nettype wire

// File: rtl/lsu_queue.sv
// ============================================================================
// Module      : lsu_queue
// Description : In-order load/store request queue with effective-address
//               generation and fixed-latency load writeback.
//               Optional: LSU_MISALIGN_TRAP_EN drops misaligned requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_queue #(
    parameter int DEPTH    = 4,
    parameter int ADDR_W   = 32,
    parameter int WORD_W   = 32,
    parameter int TAG_W    = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic         clk,
    input  logic         rstn,
    lsu_queue_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_addr  [DEPTH];
    logic [WORD_W-1:0] r_wdata [DEPTH];
    logic [TAG_W-1:0]  r_tag   [DEPTH];
    logic              r_we    [DEPTH];

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    logic [LOAD_LAT-1:0] r_pipe_valid;
    logic [TAG_W-1:0]    r_pipe_tag [LOAD_LAT];

    logic [ADDR_W-1:0] w_addr;
    logic              w_full;
    logic              w_nonempty;
    logic              w_req_fire;
    logic              w_enq;
    logic              w_deq;
    logic              w_load_issue;

    assign w_addr     = bus.req_base + {{(ADDR_W-16){bus.req_offset[15]}}, bus.req_offset};
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_nonempty = (r_count != '0);

    // Ready is forced low while reset is held so nothing is handshaken away.
    assign bus.req_ready = !w_full && !rstn;
    assign w_req_fire    = bus.req_valid && bus.req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
    logic              w_misaligned;
    logic              r_misalign;
    logic [ADDR_W-1:0] r_misalign_addr;

    assign w_misaligned = (w_addr[1:0] != 2'b00);
    assign w_enq        = w_req_fire && !w_misaligned;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_misalign      <= 1'b0;
            r_misalign_addr <= '0;
        end else begin
            r_misalign <= w_req_fire && w_misaligned;
            if (w_req_fire && w_misaligned) begin
                r_misalign_addr <= w_addr;
            end
        end
    end

    assign bus.misalign      = r_misalign;
    assign bus.misalign_addr = r_misalign_addr;
`else
    assign w_enq             = w_req_fire;
    assign bus.misalign      = 1'b0;
    assign bus.misalign_addr = '0;
`endif

    assign w_deq        = w_nonempty && bus.mem_accepted;
    assign w_load_issue = w_deq && !r_we[r_head];

    // Head fields are gated so the memory side sees zeros when idle.
    assign bus.mem_order   = w_nonempty;
    assign bus.mem_io      = w_nonempty && r_we[r_head];
    assign bus.mem_address = w_nonempty ? r_addr[r_head]  : '0;
    assign bus.mem_wdata   = w_nonempty ? r_wdata[r_head] : '0;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail]  <= w_addr;
            r_wdata[r_tail] <= bus.req_wdata;
            r_tag[r_tail]   <= bus.req_tag;
            r_we[r_tail]    <= bus.req_we;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_deq) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_pipe_valid <= '0;
            for (int i = 0; i < LOAD_LAT; i++) begin
                r_pipe_tag[i] <= '0;
            end
        end else begin
            for (int i = LOAD_LAT - 1; i > 0; i--) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_tag[i]   <= r_pipe_tag[i-1];
            end
            r_pipe_valid[0] <= w_load_issue;
            r_pipe_tag[0]   <= r_tag[r_head];
        end
    end

    // Load data is taken straight from the memory bus in the exit cycle.
    assign bus.wb_valid = r_pipe_valid[LOAD_LAT-1];
    assign bus.wb_tag   = r_pipe_valid[LOAD_LAT-1] ? r_pipe_tag[LOAD_LAT-1] : '0;
    assign bus.wb_data  = r_pipe_valid[LOAD_LAT-1] ? bus.mem_rdata : '0;

    assign bus.busy = w_nonempty || (|r_pipe_valid);

endmodule

`default_nettype wire

// File: doc/lsu_queue.md
# lsu_queue

Load/store request queue between the execute stage and the data-memory access block. It accepts memory operations from execute with a valid/ready handshake and computes the effective address base + sign-extended offset. It buffers up to DEPTH operations in order and issues one per cycle to the memory access block. Load data is captured on the fixed BRAM read latency and returned to writeback tagged with its destination register.

## Interface
Parameters:
- DEPTH, 4: queue entries; power of two, ≥ 2
- ADDR_W, 32: byte-address width
- WORD_W, 32: data word width
- TAG_W, 5: destination-register tag width
- LOAD_LAT, 1: cycles from accepted load issue to valid mem_rdata; ≥ 1

Ports:
- clk  in  1  clock; all state updates on rising edge
- rstn  in  1  reset, asynchronous, active-high (1 = reset asserted)
- req_valid  in  1  execute presents an operation
- req_ready  out  1  queue can take an operation
- req_we  in  1  1 = store, 0 = load
- req_base  in  ADDR_W  base register value
- req_offset  in  16  signed immediate offset
- req_wdata  in  WORD_W  store data
- req_tag  in  TAG_W  load destination tag
- mem_order  out  1  request valid to memory block
- mem_io  out  1  1 = write, 0 = read
- mem_address  out  ADDR_W  byte address
- mem_wdata  out  WORD_W  store data
- mem_accepted  in  1  memory took the request this cycle
- mem_rdata  in  WORD_W  load data from memory block
- wb_valid  out  1  one-cycle pulse, load result valid
- wb_tag  out  TAG_W  tag of returned load
- wb_data  out  WORD_W  returned load data
- misalign  out  1  one-cycle pulse, misaligned request dropped
- misalign_addr  out  ADDR_W  offending address, held until next misalign
- busy  out  1  queue non-empty or a load is in flight

## Operation
- Enqueue on `req_valid & req_ready`. Stored fields: we, wdata, tag, and addr = req_base + sign_extend(req_offset), truncated to ADDR_W. Wrap-around past 2^ADDR_W is silent.
- `req_ready = !full` and is 0 while rstn is asserted. There is no full-bypass: a full queue refuses input even if it dequeues in the same cycle.
- The queue is circular with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. Simultaneous enqueue and dequeue leaves count unchanged.
- Issue: when count ≠ 0, drive mem_order=1 with the head entry's fields (mem_io = we), combinationally from the head. Pop the head when mem_accepted=1.
- An entry enqueued in cycle N is issued no earlier than N+1. The queue has no same-cycle pass-through.
- Stores retire at acceptance and produce no writeback.
- Each accepted load enters a LOAD_LAT-deep valid/tag shift pipeline. At its exit: wb_valid=1, wb_tag=tag, wb_data=mem_rdata sampled that cycle.
- Results return strictly in issue order, at most one per cycle. Writeback cannot stall.
- `busy = (count ≠ 0) | any load-pipeline valid`.
- Reset mid-operation clears pointers, count, and all load-pipeline valids. In-flight loads are discarded and produce no wb_valid.

## Timing
- Reset values: req_ready=0 while reset is asserted and 1 from the first cycle after release. mem_order=0, mem_io=0, mem_address=0, mem_wdata=0, wb_valid=0, wb_tag=0, wb_data=0, misalign=0, misalign_addr=0, busy=0.
- Best-case load: request in cycle N, mem_order in N+1, wb_valid in N+1+LOAD_LAT.
- Sustained throughput is one operation per cycle when mem_accepted is held at 1.
- If mem_accepted=0, all mem_* outputs hold stable until acceptance.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A request with addr[1:0] ≠ 0 completes its handshake but is not enqueued.
  - misalign pulses in the next cycle, and misalign_addr is registered with the address.
- Undefined:
  - All requests are enqueued with addr unmodified. The memory block ignores the low two bits.
  - misalign and misalign_addr are tied to 0.

## Test plan
- Reset release, then one load with base=0x100, offset=-4, tag=3, mem_rdata=0xDEADBEEF, LOAD_LAT=1 -> mem_address=0xFC with mem_io=0 one cycle after the request; next cycle wb_valid=1, wb_tag=3, wb_data=0xDEADBEEF.
- Store base=0x20, offset=8, wdata=0x12345678 -> mem_order=1, mem_io=1, mem_address=0x28, mem_wdata=0x12345678; no wb_valid.
- mem_accepted=0 while issuing 5 requests with DEPTH=4 -> req_ready drops after the 4th enqueue and the 5th waits; raising mem_accepted issues 0..3 in order, after which the 5th is taken.
- Back-to-back loads with tags 1, 2, 3 and mem_accepted=1 -> wb_valid on three consecutive cycles with tags 1, 2, 3 in order.
- With LSU_MISALIGN_TRAP_EN, load at base=0x101, offset=0 -> no mem_order; misalign=1 for one cycle; misalign_addr=0x101.
- Assert rstn with two loads in flight -> no wb_valid afterwards, busy=0, and req_ready=1 after release.
